// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral bus responder.
// Holds the register index enum, byte offsets, CTRL bit positions, and a byte-enable merge helper.
package periph_pkg;

  // Register index as decoded from addr[4:2].
  typedef enum logic [2:0] {
    REG_LED      = 3'd0,
    REG_CTRL     = 3'd1,
    REG_MTIME_LO = 3'd2,
    REG_MTIME_HI = 3'd3,
    REG_CMP_LO   = 3'd4,
    REG_CMP_HI   = 3'd5,
    REG_PRESCALE = 3'd6,
    REG_STATUS   = 3'd7
  } reg_idx_e;

  // Byte offsets within the window.
  localparam logic [7:0] OFF_LED      = 8'h00;
  localparam logic [7:0] OFF_CTRL     = 8'h04;
  localparam logic [7:0] OFF_MTIME_LO = 8'h08;
  localparam logic [7:0] OFF_MTIME_HI = 8'h0C;
  localparam logic [7:0] OFF_CMP_LO   = 8'h10;
  localparam logic [7:0] OFF_CMP_HI   = 8'h14;
  localparam logic [7:0] OFF_PRESCALE = 8'h18;
  localparam logic [7:0] OFF_STATUS   = 8'h1C;

  // CTRL bit positions.
  localparam int CTRL_TIMER_EN = 0;
  localparam int CTRL_IRQ_EN   = 1;

  // Replace the enabled bytes of old_word with the matching bytes of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/periph_timer.sv
// Prescaled 64-bit machine timer with compare register.
// Ports:
//   clk_sys, rst_sys_n       clock, asynchronous active-low reset
//   timer_en                 counting enable (holds prescaler and mtime when low)
//   prescale                 prescaler terminal value
//   prescale_wr              PRESCALE was written: restart the prescaler
//   mtime_lo_wr/hi_wr        load a half of mtime from wr_word
//   cmp_lo_wr/hi_wr          load a half of mtimecmp from wr_word
//   wr_word                  already byte-merged write data
//   mtime_lo_rd              MTIME_LO is being read: capture the high half
//   mtime, cmp               current timer and compare values
//   mtime_hi_shadow          high half captured by the last MTIME_LO read
//   cmp_hit                  mtime >= mtimecmp
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        timer_en,
  input  logic [15:0] prescale,
  input  logic        prescale_wr,
  input  logic        mtime_lo_wr,
  input  logic        mtime_hi_wr,
  input  logic        cmp_lo_wr,
  input  logic        cmp_hi_wr,
  input  logic [31:0] wr_word,
  input  logic        mtime_lo_rd,
  output logic [63:0] mtime,
  output logic [63:0] cmp,
  output logic [31:0] mtime_hi_shadow,
  output logic        cmp_hit
);

  logic [7:0]  presc_cnt_reg;
  logic [63:0] mtime_reg;
  logic [63:0] cmp_reg;
  logic [31:0] shadow_reg;
  logic        presc_match;
  logic        tick;

  // The counter is only 8 bits; a PRESCALE above 255 never matches and stalls mtime.
  assign presc_match = ({8'd0, presc_cnt_reg} == prescale);
  assign tick        = timer_en & presc_match;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      presc_cnt_reg <= 8'd0;
    end else if (prescale_wr) begin
      presc_cnt_reg <= 8'd0;
    end else if (timer_en) begin
      presc_cnt_reg <= presc_match ? 8'd0 : presc_cnt_reg + 8'd1;
    end
  end

  // A bus write to either half takes priority; a tick in that cycle is dropped.
  // Writing LO never carries into HI.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      mtime_reg <= 64'd0;
    end else if (mtime_lo_wr) begin
      mtime_reg <= {mtime_reg[63:32], wr_word};
    end else if (mtime_hi_wr) begin
      mtime_reg <= {wr_word, mtime_reg[31:0]};
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      cmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (cmp_lo_wr) begin
      cmp_reg <= {cmp_reg[63:32], wr_word};
    end else if (cmp_hi_wr) begin
      cmp_reg <= {wr_word, cmp_reg[31:0]};
    end
  end

  // Snapshot HI at the same instant LO is returned so a LO-then-HI read pair is coherent.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      shadow_reg <= 32'd0;
    end else if (mtime_lo_rd) begin
      shadow_reg <= mtime_reg[63:32];
    end
  end

  assign mtime           = mtime_reg;
  assign cmp             = cmp_reg;
  assign mtime_hi_shadow = shadow_reg;
  assign cmp_hit         = (mtime_reg >= cmp_reg);

endmodule

// File: rtl/periph_bus_resp.sv
// Data-bus responder for the req/gnt/rvalid protocol, hosting LED, CTRL,
// a prescaled 64-bit timer with compare, PRESCALE and STATUS registers.
// Ports:
//   clk_sys, rst_sys_n      clock, asynchronous active-low reset
//   req_i, we_i, be_i       request, write flag, byte enables
//   addr_i, wdata_i         byte address (bits [4:2] select register), write data
//   gnt_o                   grant, equal to req_i
//   rvalid_o, err_o, rdata_o  registered response, one cycle after each grant
//   led_o                   LED register contents
//   irq_timer_o             registered level timer interrupt
module periph_bus_resp
  import periph_pkg::*;
#(
  parameter int unsigned LedWidth    = 4,
  parameter logic [15:0] PrescaleRst = 16'd0
) (
  input  logic                clk_sys,
  input  logic                rst_sys_n,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic                err_o,
  output logic [31:0]         rdata_o,
  output logic [LedWidth-1:0] led_o,
  output logic                irq_timer_o
);

  reg_idx_e            idx;
  logic                err_cond;
  logic                accept;
  logic                wr_en;
  logic                rd_en;
  logic [31:0]         cur_word;
  logic [31:0]         rd_word;
  logic [31:0]         wr_word;

  logic [LedWidth-1:0] led_reg;
  logic [1:0]          ctrl_reg;
  logic [15:0]         prescale_reg;
  logic                rvalid_reg;
  logic                err_reg;
  logic [31:0]         rdata_reg;
  logic                irq_reg;

  logic [63:0]         mtime;
  logic [63:0]         cmp;
  logic [31:0]         mtime_hi_shadow;
  logic                cmp_hit;

  // Upper address bits are decoded by the surrounding fabric.
  logic                unused_addr;
  assign unused_addr = ^{addr_i[31:5]};

  assign idx      = reg_idx_e'(addr_i[4:2]);
  assign err_cond = (addr_i[1:0] != 2'b00) | (~we_i & (be_i == 4'd0));
  assign accept   = req_i & ~err_cond;
  // be=0 writes are accepted with a normal response but touch nothing.
  assign wr_en    = accept & we_i & (be_i != 4'd0);
  assign rd_en    = accept & ~we_i;

  // Actual register contents, used as the base for byte-merged writes.
  always_comb begin
    cur_word = 32'd0;
    unique case (idx)
      REG_LED:      cur_word = 32'(led_reg);
      REG_CTRL:     cur_word = 32'(ctrl_reg);
      REG_MTIME_LO: cur_word = mtime[31:0];
      REG_MTIME_HI: cur_word = mtime[63:32];
      REG_CMP_LO:   cur_word = cmp[31:0];
      REG_CMP_HI:   cur_word = cmp[63:32];
      REG_PRESCALE: cur_word = 32'(prescale_reg);
      REG_STATUS:   cur_word = 32'(cmp_hit);
      default:      cur_word = 32'd0;
    endcase
  end

  // MTIME_HI reads return the shadow; every other register reads its contents.
  assign rd_word = (idx == REG_MTIME_HI) ? mtime_hi_shadow : cur_word;
  assign wr_word = merge_bytes(cur_word, wdata_i, be_i);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      led_reg      <= '0;
      ctrl_reg     <= 2'd0;
      prescale_reg <= PrescaleRst;
    end else if (wr_en) begin
      if (idx == REG_LED)      led_reg      <= wr_word[LedWidth-1:0];
      if (idx == REG_CTRL)     ctrl_reg     <= wr_word[1:0];
      if (idx == REG_PRESCALE) prescale_reg <= wr_word[15:0];
    end
  end

  periph_timer u_timer (
    .clk_sys         (clk_sys),
    .rst_sys_n       (rst_sys_n),
    .timer_en        (ctrl_reg[CTRL_TIMER_EN]),
    .prescale        (prescale_reg),
    .prescale_wr     (wr_en & (idx == REG_PRESCALE)),
    .mtime_lo_wr     (wr_en & (idx == REG_MTIME_LO)),
    .mtime_hi_wr     (wr_en & (idx == REG_MTIME_HI)),
    .cmp_lo_wr       (wr_en & (idx == REG_CMP_LO)),
    .cmp_hi_wr       (wr_en & (idx == REG_CMP_HI)),
    .wr_word         (wr_word),
    .mtime_lo_rd     (rd_en & (idx == REG_MTIME_LO)),
    .mtime           (mtime),
    .cmp             (cmp),
    .mtime_hi_shadow (mtime_hi_shadow),
    .cmp_hit         (cmp_hit)
  );

  // Response pipeline: one response per grant, data zeroed for writes and errors.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rdata_reg  <= 32'd0;
      irq_reg    <= 1'b0;
    end else begin
      rvalid_reg <= req_i;
      err_reg    <= req_i & err_cond;
      rdata_reg  <= rd_en ? rd_word : 32'd0;
      irq_reg    <= ctrl_reg[CTRL_IRQ_EN] & cmp_hit;
    end
  end

  assign gnt_o       = req_i;
  assign rvalid_o    = rvalid_reg;
  assign err_o       = err_reg;
  assign rdata_o     = rdata_reg;
  assign led_o       = led_reg;
  assign irq_timer_o = irq_reg;

endmodule

// File: tb/tb_periph_bus_resp.sv
// Self-checking bench for periph_bus_resp: directed scenarios plus a randomized
// register-access phase checked against a byte-level reference model.
module tb_periph_bus_resp;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err, irq;
  logic [31:0] rdata;
  logic [3:0]  led;

  int checks = 0;
  int errors = 0;

  periph_bus_resp #(.LedWidth(4), .PrescaleRst(16'd0)) dut (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .req_i       (req),
    .we_i        (we),
    .be_i        (be),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .err_o       (err),
    .rdata_o     (rdata),
    .led_o       (led),
    .irq_timer_o (irq)
  );

  always #5 clk_sys = ~clk_sys;

  // One transaction: inputs change on the falling edge, response sampled one falling edge later.
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic g, output logic v,
                     output logic e, output logic [31:0] r);
    @(negedge clk_sys);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1 g = gnt;
    @(negedge clk_sys);
    req = 1'b0;
    v = rvalid; e = err; r = rdata;
    $display("txn we=%0b addr=%h be=%h wdata=%h -> gnt=%0b rvalid=%0b err=%0b rdata=%h",
             w, a, b, d, g, v, e, r);
  endtask

  task automatic test_reset();
    logic g, v, e;
    logic [31:0] r;
    logic [31:0] exp_val [8];
    exp_val = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    rst_sys_n = 1'b0;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({rvalid, err, rdata, led, irq} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rvalid=%b err=%b rdata=%h led=%h irq=%b required all 0",
               rvalid, err, rdata, led, irq);
    end
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 32'(i * 4), 4'hF, 32'h0, g, v, e, r);
      checks++;
      if (v !== 1'b1 || e !== 1'b0 || r !== exp_val[i]) begin
        errors++;
        $display("FAIL reset_read_%0d: got rvalid=%b err=%b rdata=%h required 1 0 %h",
                 i, v, e, r, exp_val[i]);
      end
    end
  endtask

  task automatic test_led();
    logic g, v, e;
    logic [31:0] r;
    bus(1'b1, 32'h00, 4'hF, 32'hA, g, v, e, r);
    checks++;
    if (g !== 1'b1 || v !== 1'b1 || e !== 1'b0 || r !== 32'h0 || led !== 4'hA) begin
      errors++;
      $display("FAIL led_write: got gnt=%b rvalid=%b err=%b rdata=%h led=%h required 1 1 0 0 a",
               g, v, e, r, led);
    end
    bus(1'b0, 32'h00, 4'hF, 32'h0, g, v, e, r);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || r !== 32'hA) begin
      errors++;
      $display("FAIL led_read: got rvalid=%b err=%b rdata=%h required 1 0 0000000a", v, e, r);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_sys);
    req = 1'b1; we = 1'b1; addr = 32'h10; be = 4'h1; wdata = 32'h12;
    @(negedge clk_sys);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_write_resp: got rvalid=%b err=%b rdata=%h required 1 0 0", rvalid, err, rdata);
    end
    we = 1'b0;
    @(negedge clk_sys);
    req = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'hFFFF_FF12) begin
      errors++;
      $display("FAIL b2b_read_resp: got rvalid=%b err=%b rdata=%h required 1 0 ffffff12", rvalid, err, rdata);
    end
    @(negedge clk_sys);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_idle: got rvalid=%b rdata=%h required 0 0", rvalid, rdata);
    end
  endtask

  task automatic test_errors();
    logic g, v, e;
    logic [31:0] r;
    bus(1'b1, 32'h00, 4'hF, 32'h5, g, v, e, r);
    bus(1'b0, 32'h01, 4'hF, 32'h0, g, v, e, r);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL err_misaligned_read: got rvalid=%b err=%b rdata=%h required 1 1 0", v, e, r);
    end
    bus(1'b1, 32'h02, 4'hF, 32'hF, g, v, e, r);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0 || led !== 4'h5) begin
      errors++;
      $display("FAIL err_misaligned_write: got rvalid=%b err=%b rdata=%h led=%h required 1 1 0 5", v, e, r, led);
    end
    bus(1'b0, 32'h00, 4'h0, 32'h0, g, v, e, r);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL err_read_be0: got rvalid=%b err=%b rdata=%h required 1 1 0", v, e, r);
    end
    bus(1'b1, 32'h00, 4'h0, 32'h3, g, v, e, r);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || led !== 4'h5) begin
      errors++;
      $display("FAIL write_be0: got rvalid=%b err=%b led=%h required 1 0 5", v, e, led);
    end
    bus(1'b0, 32'h00, 4'hF, 32'h0, g, v, e, r);
    checks++;
    if (e !== 1'b0 || r !== 32'h5) begin
      errors++;
      $display("FAIL err_no_change: got err=%b rdata=%h required 0 00000005", e, r);
    end
  endtask

  task automatic test_timer();
    logic g, v, e;
    logic [31:0] r;
    bus(1'b1, 32'h04, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h18, 4'hF, 32'h3, g, v, e, r);
    bus(1'b1, 32'h0C, 4'hF, 32'h55, g, v, e, r);
    bus(1'b1, 32'h08, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h04, 4'hF, 32'h1, g, v, e, r);
    repeat (39) @(negedge clk_sys);
    bus(1'b1, 32'h04, 4'hF, 32'h0, g, v, e, r);
    bus(1'b0, 32'h08, 4'hF, 32'h0, g, v, e, r);
    checks++;
    if (e !== 1'b0 || r < 32'd9 || r > 32'd11) begin
      errors++;
      $display("FAIL timer_mtime_lo: got err=%b rdata=%0d required 10 (+/-1)", e, r);
    end
    bus(1'b0, 32'h0C, 4'hF, 32'h0, g, v, e, r);
    checks++;
    if (e !== 1'b0 || r !== 32'h55) begin
      errors++;
      $display("FAIL timer_hi_shadow: got err=%b rdata=%h required 00000055", e, r);
    end
  endtask

  task automatic test_irq();
    logic g, v, e;
    logic [31:0] r;
    int n;
    bus(1'b1, 32'h18, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h08, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h0C, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h14, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h10, 4'hF, 32'h5, g, v, e, r);
    bus(1'b1, 32'h04, 4'hF, 32'h3, g, v, e, r);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_low_at_start: got %b required 0", irq);
    end
    n = 0;
    while (irq !== 1'b1 && n < 30) begin
      @(negedge clk_sys);
      n++;
    end
    // mtime reaches 5 five clocks after enable; irq is one register later.
    checks++;
    if (irq !== 1'b1 || n < 5 || n > 7) begin
      errors++;
      $display("FAIL irq_rise: got irq=%b after %0d clks required 1 after 5..7", irq, n);
    end
    @(negedge clk_sys);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_level: got %b required 1", irq);
    end
    bus(1'b1, 32'h10, 4'hF, 32'd100, g, v, e, r);
    @(negedge clk_sys);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_drop: got %b required 0", irq);
    end
    bus(1'b1, 32'h04, 4'hF, 32'h0, g, v, e, r);
  endtask

  // Randomized accesses with timer and IRQ disabled so the model state is fully known.
  task automatic test_random();
    logic g, v, e;
    logic [31:0] r;
    logic [3:0]  m_led;
    logic [63:0] m_cmp, m_mtime;
    logic [15:0] m_presc;
    logic [31:0] m_shadow, cur, nw, exp_r, a, d;
    logic [3:0]  b;
    logic        w, exp_e;
    int          ri;
    bus(1'b1, 32'h04, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h00, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h08, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h0C, 4'hF, 32'h0, g, v, e, r);
    bus(1'b1, 32'h10, 4'hF, 32'hFFFF_FFFF, g, v, e, r);
    bus(1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, g, v, e, r);
    bus(1'b1, 32'h18, 4'hF, 32'h0, g, v, e, r);
    bus(1'b0, 32'h08, 4'hF, 32'h0, g, v, e, r);
    m_led = 4'h0; m_cmp = '1; m_mtime = 64'd0; m_presc = 16'd0; m_shadow = 32'd0;
    for (int t = 0; t < 60; t++) begin
      ri = $urandom_range(0, 7);
      if (ri == 1) ri = 0;
      a = 32'(ri * 4);
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      b = 4'($urandom_range(0, 15));
      d = $urandom;
      case (ri)
        0: cur = {28'd0, m_led};
        2: cur = m_mtime[31:0];
        3: cur = m_mtime[63:32];
        4: cur = m_cmp[31:0];
        5: cur = m_cmp[63:32];
        6: cur = {16'd0, m_presc};
        default: cur = {31'd0, (m_mtime >= m_cmp)};
      endcase
      exp_e = (a[1:0] != 2'b00) || (!w && b == 4'h0);
      exp_r = 32'd0;
      if (!exp_e && !w) begin
        exp_r = (ri == 3) ? m_shadow : cur;
        if (ri == 2) m_shadow = m_mtime[63:32];
      end else if (!exp_e && w) begin
        nw = cur;
        for (int k = 0; k < 4; k++) if (b[k]) nw[k*8 +: 8] = d[k*8 +: 8];
        case (ri)
          0: m_led = nw[3:0];
          2: m_mtime[31:0] = nw;
          3: m_mtime[63:32] = nw;
          4: m_cmp[31:0] = nw;
          5: m_cmp[63:32] = nw;
          6: m_presc = nw[15:0];
          default: ;
        endcase
      end
      bus(w, a, b, d, g, v, e, r);
      checks++;
      if (g !== 1'b1 || v !== 1'b1 || e !== exp_e || r !== exp_r || led !== m_led) begin
        errors++;
        $display("FAIL rand_%0d: got gnt=%b rvalid=%b err=%b rdata=%h led=%h required 1 1 %b %h %h",
                 t, g, v, e, r, led, exp_e, exp_r, m_led);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_sys);
    req = 1'b1; we = 1'b0; addr = 32'h00; be = 4'hF;
    #1 rst_sys_n = 1'b0;
    @(negedge clk_sys);
    req = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || led !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_drop: got rvalid=%b led=%h required 0 0", rvalid, led);
    end
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got rvalid=%b required 0", rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_back_to_back();
    test_errors();
    test_timer();
    test_irq();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
